// File: rtl/cp0_multi_irq.sv
// Coprocessor-0 for the 5-stage MIPS pipeline: SR/Cause/EPC/PRId, N hw + 2 sw interrupts, eret EPC bypass; CP0_TIMER_EN adds Count/Compare.
// Latency: Req, CP0Out, EPCOut combinational; state updates at next clk edge; IntAck one cycle after an interrupt is taken.
// Backpressure: none; Req flushes stage M and takes priority over any same-cycle mtc0 write.
module cp0_multi_irq #(
  parameter int          NUM_HWINT = 6,
  parameter logic [31:0] PRID_VAL  = 32'h0000_4D50
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [4:0]           CP0Add,
  input  logic [31:0]          CP0In,
  output logic [31:0]          CP0Out,
  input  logic [31:0]          VPC,
  input  logic                 BDIn,
  input  logic [4:0]           ExcCodeIn,
  input  logic [NUM_HWINT-1:0] HWInt,
  input  logic                 EXLClr,
  output logic [31:0]          EPCOut,
  output logic                 Req,
  output logic                 IntAck
);
  // Index of the topmost hardware line inside the 8-bit IP field.
  localparam int TOP_IP = 2 + NUM_HWINT - 1;

  logic [7:0]           sr_im;
  logic                 sr_exl;
  logic                 sr_ie;
  logic                 cause_bd;
  logic [1:0]           ip_sw;
  logic [NUM_HWINT-1:0] ip_hw;
  logic [4:0]           cause_exc;
  logic [31:0]          epc;
  logic                 int_ack_q;
  logic                 timer_pend;

  logic [7:0]  ip;
  logic        int_req;
  logic        exc_req;
  logic        req;
  logic        wr_ok;
  logic        wr_sr;
  logic        wr_cause;
  logic        wr_epc;
  logic [31:0] vpc_al;
  logic [31:0] epc_next;
  logic [31:0] rd_dat;

  always_comb begin
    ip            = '0;
    ip[1:0]       = ip_sw;
    ip[2 +: NUM_HWINT] = ip_hw;
    ip[TOP_IP]    = ip[TOP_IP] | timer_pend;
  end

  assign int_req = (|(ip & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req = (ExcCodeIn != 5'd0) & ~sr_exl;
  assign req     = int_req | exc_req;

  // A taken interrupt/exception drops any mtc0 in the same cycle.
  assign wr_ok    = en & ~req;
  assign wr_sr    = wr_ok & (CP0Add == 5'd12);
  assign wr_cause = wr_ok & (CP0Add == 5'd13);
  assign wr_epc   = wr_ok & (CP0Add == 5'd14);

  assign vpc_al   = VPC & 32'hFFFF_FFFC;
  assign epc_next = BDIn ? (vpc_al - 32'd4) : vpc_al;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      ip_sw     <= '0;
      ip_hw     <= '0;
      cause_exc <= '0;
      epc       <= '0;
      int_ack_q <= 1'b0;
    end else begin
      ip_hw     <= HWInt;
      int_ack_q <= int_req;
      if (req) begin
        sr_exl    <= 1'b1;
        cause_bd  <= BDIn;
        cause_exc <= int_req ? 5'd0 : ExcCodeIn;
        epc       <= epc_next;
      end else begin
        if (wr_sr) begin
          sr_im  <= CP0In[15:8];
          sr_exl <= CP0In[1];
          sr_ie  <= CP0In[0];
        end
        // eret overrides an mtc0 that tries to set EXL in the same cycle.
        if (EXLClr) sr_exl <= 1'b0;
        if (wr_cause) ip_sw <= CP0In[9:8];
        if (wr_epc) epc <= CP0In & 32'hFFFF_FFFC;
      end
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count;
  logic [31:0] compare;
  logic        wr_count;
  logic        wr_compare;

  assign wr_count   = wr_ok & (CP0Add == 5'd9);
  assign wr_compare = wr_ok & (CP0Add == 5'd11);

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      compare    <= '0;
      timer_pend <= 1'b0;
    end else begin
      count <= wr_count ? CP0In : count + 32'd1;
      if (wr_compare) begin
        compare    <= CP0In;
        timer_pend <= 1'b0;
      end else if ((count == compare) && (compare != 32'd0)) begin
        timer_pend <= 1'b1;
      end
    end
  end
`else
  assign timer_pend = 1'b0;
`endif

  always_comb begin
    rd_dat = '0;
    case (CP0Add)
`ifdef CP0_TIMER_EN
      5'd9:  rd_dat = count;
      5'd11: rd_dat = compare;
`endif
      5'd12: rd_dat = {16'd0, sr_im, 6'd0, sr_exl, sr_ie};
      5'd13: rd_dat = {cause_bd, 15'd0, ip, 1'b0, cause_exc, 2'b00};
      5'd14: rd_dat = epc;
      5'd15: rd_dat = PRID_VAL;
      default: rd_dat = '0;
    endcase
  end

  // Forward a same-cycle mtc0 EPC so a following eret redirects correctly.
  assign EPCOut = (en & (CP0Add == 5'd14) & ~req) ? (CP0In & 32'hFFFF_FFFC) : epc;
  assign CP0Out = rd_dat;
  assign Req    = req;
  assign IntAck = int_ack_q;

endmodule

// File: tb/tb_cp0_multi_irq.sv
// Bench for cp0_multi_irq: vector table plus hand sequences, expectations queued on drive and compared mid-cycle.
module tb_cp0_multi_irq;
  localparam int          NHW  = 6;
  localparam logic [31:0] PRID = 32'h0000_4D50;

  logic           clk = 1'b0;
  logic           reset;
  logic           en;
  logic [4:0]     CP0Add;
  logic [31:0]    CP0In;
  logic [31:0]    CP0Out;
  logic [31:0]    VPC;
  logic           BDIn;
  logic [4:0]     ExcCodeIn;
  logic [NHW-1:0] HWInt;
  logic           EXLClr;
  logic [31:0]    EPCOut;
  logic           Req;
  logic           IntAck;

  cp0_multi_irq #(.NUM_HWINT(NHW), .PRID_VAL(PRID)) dut (
    .clk(clk), .reset(reset), .en(en), .CP0Add(CP0Add), .CP0In(CP0In),
    .CP0Out(CP0Out), .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn),
    .HWInt(HWInt), .EXLClr(EXLClr), .EPCOut(EPCOut), .Req(Req), .IntAck(IntAck)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic           rst;
    logic           en;
    logic [4:0]     addr;
    logic [31:0]    din;
    logic [31:0]    vpc;
    logic           bd;
    logic [4:0]     exc;
    logic [NHW-1:0] hw;
    logic           exlclr;
    logic           req;
    logic [31:0]    rd;
    logic [31:0]    epc;
    logic           ack;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   step_no = 0;

  function automatic vec_t mk(input logic rst, input logic e, input logic [4:0] a,
                              input logic [31:0] d, input logic [31:0] v, input logic b,
                              input logic [4:0] x, input logic [NHW-1:0] h, input logic c,
                              input logic q, input logic [31:0] r, input logic [31:0] p,
                              input logic k);
    vec_t t;
    t.rst = rst; t.en = e; t.addr = a; t.din = d; t.vpc = v; t.bd = b;
    t.exc = x; t.hw = h; t.exlclr = c; t.req = q; t.rd = r; t.epc = p; t.ack = k;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", nm, step_no, act, exp);
    end
  endtask

  // Drive one cycle, queue its expectation, compare at mid-cycle, then advance past the edge.
  task automatic step(input vec_t v);
    vec_t e;
    reset = v.rst; en = v.en; CP0Add = v.addr; CP0In = v.din; VPC = v.vpc;
    BDIn = v.bd; ExcCodeIn = v.exc; HWInt = v.hw; EXLClr = v.exlclr;
    sb.push_back(v);
    #4;
    e = sb.pop_front();
    chk("req",     {31'd0, Req},    {31'd0, e.req});
    chk("cp0out",  CP0Out,          e.rd);
    chk("epcout",  EPCOut,          e.epc);
    chk("intack",  {31'd0, IntAck}, {31'd0, e.ack});
    step_no++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                rst en addr din            vpc        bd exc hw  eret  req rd             epc        ack
    tbl.push_back(mk(0, 0, 12, 32'h0,          32'h0,     0, 0,  0, 0,    0, 32'h0,         32'h0,     0));
    tbl.push_back(mk(0, 0, 13, 32'h0,          32'h0,     0, 0,  0, 0,    0, 32'h0,         32'h0,     0));
    tbl.push_back(mk(0, 0, 14, 32'h0,          32'h0,     0, 0,  0, 0,    0, 32'h0,         32'h0,     0));
    tbl.push_back(mk(0, 0, 15, 32'h0,          32'h0,     0, 0,  0, 0,    0, PRID,          32'h0,     0));
    tbl.push_back(mk(0, 1, 12, 32'h401,        32'h0,     0, 0,  0, 0,    0, 32'h0,         32'h0,     0));
    tbl.push_back(mk(0, 0, 12, 32'h0,          32'h3008,  0, 0,  1, 0,    0, 32'h401,       32'h0,     0));
    tbl.push_back(mk(0, 0, 13, 32'h0,          32'h3008,  0, 0,  1, 0,    1, 32'h400,       32'h0,     0));
    tbl.push_back(mk(0, 0, 14, 32'h0,          32'h0,     0, 0,  0, 0,    0, 32'h3008,      32'h3008,  1));
    tbl.push_back(mk(0, 0, 13, 32'h0,          32'h0,     0, 0,  0, 0,    0, 32'h0,         32'h3008,  0));
    tbl.push_back(mk(0, 0, 12, 32'h0,          32'h0,     0, 0,  0, 0,    0, 32'h403,       32'h3008,  0));
    tbl.push_back(mk(0, 0, 12, 32'h0,          32'h0,     0, 0,  0, 1,    0, 32'h403,       32'h3008,  0));
    tbl.push_back(mk(0, 0, 12, 32'h0,          32'h0,     0, 0,  0, 0,    0, 32'h401,       32'h3008,  0));
    tbl.push_back(mk(0, 0, 13, 32'h0,          32'h3010,  1, 10, 0, 0,    1, 32'h0,         32'h3008,  0));
    tbl.push_back(mk(0, 0, 13, 32'h0,          32'h0,     0, 0,  0, 0,    0, 32'h8000_0028, 32'h300C,  0));
    tbl.push_back(mk(0, 0, 14, 32'h0,          32'h0,     0, 3,  0, 0,    0, 32'h300C,      32'h300C,  0));
    tbl.push_back(mk(0, 1, 12, 32'h403,        32'h0,     0, 0,  0, 1,    0, 32'h403,       32'h300C,  0));
    tbl.push_back(mk(0, 0, 12, 32'h0,          32'h0,     0, 0,  0, 0,    0, 32'h401,       32'h300C,  0));
    tbl.push_back(mk(0, 1, 12, 32'hC01,        32'h0,     0, 0,  2, 0,    0, 32'h401,       32'h300C,  0));
    tbl.push_back(mk(0, 1, 14, 32'h4000,       32'h3020,  0, 12, 2, 0,    1, 32'h300C,      32'h300C,  0));
    tbl.push_back(mk(0, 0, 14, 32'h0,          32'h0,     0, 0,  0, 0,    0, 32'h3020,      32'h3020,  1));
    tbl.push_back(mk(0, 0, 13, 32'h0,          32'h0,     0, 0,  0, 0,    0, 32'h0,         32'h3020,  0));
    tbl.push_back(mk(0, 0, 12, 32'h0,          32'h0,     0, 0,  0, 1,    0, 32'hC03,       32'h3020,  0));
    tbl.push_back(mk(0, 1, 12, 32'h101,        32'h0,     0, 0,  0, 0,    0, 32'hC01,       32'h3020,  0));
    tbl.push_back(mk(0, 1, 13, 32'h100,        32'h0,     0, 0,  0, 0,    0, 32'h0,         32'h3020,  0));
    tbl.push_back(mk(0, 0, 13, 32'h0,          32'h3040,  0, 0,  0, 0,    1, 32'h100,       32'h3020,  0));
    tbl.push_back(mk(0, 1, 14, 32'h5004,       32'h0,     0, 0,  0, 0,    0, 32'h3040,      32'h5004,  1));
    tbl.push_back(mk(0, 0, 14, 32'h0,          32'h0,     0, 0,  0, 0,    0, 32'h5004,      32'h5004,  0));
    tbl.push_back(mk(0, 1, 12, 32'hFFFF_FFFF,  32'h0,     0, 0,  0, 0,    0, 32'h103,       32'h5004,  0));
    tbl.push_back(mk(0, 0, 12, 32'h0,          32'h0,     0, 0,  0, 0,    0, 32'hFF03,      32'h5004,  0));
    tbl.push_back(mk(0, 1, 13, 32'h0,          32'h0,     0, 0,  0, 0,    0, 32'h100,       32'h5004,  0));
    tbl.push_back(mk(0, 1, 13, 32'hFFFF_FFFF,  32'h0,     0, 0,  0, 0,    0, 32'h0,         32'h5004,  0));
    tbl.push_back(mk(0, 1, 13, 32'h0,          32'h0,     0, 0,  0, 0,    0, 32'h300,       32'h5004,  0));
    tbl.push_back(mk(0, 1, 7,  32'h1234,       32'h0,     0, 0,  0, 0,    0, 32'h0,         32'h5004,  0));
    tbl.push_back(mk(0, 0, 7,  32'h0,          32'h0,     0, 0,  0, 0,    0, 32'h0,         32'h5004,  0));
    tbl.push_back(mk(0, 1, 14, 32'h6007,       32'h0,     0, 0,  0, 0,    0, 32'h5004,      32'h6004,  0));
    tbl.push_back(mk(0, 0, 14, 32'h0,          32'h0,     0, 0,  0, 0,    0, 32'h6004,      32'h6004,  0));
    tbl.push_back(mk(0, 0, 12, 32'h0,          32'h0,     0, 0,  0, 1,    0, 32'hFF03,      32'h6004,  0));
    tbl.push_back(mk(0, 0, 12, 32'h0,          32'h0,     0, 0,  0, 0,    0, 32'hFF01,      32'h6004,  0));

    reset = 1'b1; en = 1'b0; CP0Add = '0; CP0In = '0; VPC = '0;
    BDIn = 1'b0; ExcCodeIn = '0; HWInt = '0; EXLClr = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[i]) step(tbl[i]);

    // Reset in the middle of a handler, with a hw line held high through it.
    step(mk(0, 0, 13, 32'h0, 32'h0,    0, 0, 1, 0, 0, 32'h0,    32'h6004, 0));
    step(mk(0, 0, 13, 32'h0, 32'h7000, 0, 0, 1, 0, 1, 32'h400,  32'h6004, 0));
    step(mk(1, 0, 12, 32'h0, 32'h0,    0, 0, 1, 0, 0, 32'hFF03, 32'h7000, 1));
    step(mk(0, 0, 13, 32'h0, 32'h0,    0, 0, 1, 0, 0, 32'h0,    32'h0,    0));
    step(mk(0, 0, 13, 32'h0, 32'h0,    0, 0, 1, 0, 0, 32'h400,  32'h0,    0));
    step(mk(0, 0, 12, 32'h0, 32'h0,    0, 0, 1, 0, 0, 32'h0,    32'h0,    0));

`ifdef CP0_TIMER_EN
    step(mk(0, 1, 11, 32'd20, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0));
    step(mk(0, 1, 9,  32'd0,  32'h0, 0, 0, 0, 0, 0, 32'd4, 32'h0, 0));
    step(mk(0, 0, 9,  32'd0,  32'h0, 0, 0, 0, 0, 0, 32'd0, 32'h0, 0));
    for (int k = 1; k <= 21; k++)
      step(mk(0, 0, 13, 32'h0, 32'h0, 0, 0, 0, 0, 0, (k > 20) ? 32'h8000 : 32'h0, 32'h0, 0));
    step(mk(0, 1, 12, 32'h8001, 32'h9000, 0, 0, 0, 0, 0, 32'h0,   32'h0,    0));
    step(mk(0, 0, 13, 32'h0,    32'h9000, 0, 0, 0, 0, 1, 32'h8000, 32'h0,   0));
    step(mk(0, 1, 11, 32'd1000, 32'h0,    0, 0, 0, 0, 0, 32'd20,  32'h9000, 1));
    step(mk(0, 0, 13, 32'h0,    32'h0,    0, 0, 0, 0, 0, 32'h0,   32'h9000, 0));
`else
    step(mk(0, 1, 9,  32'h55, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0));
    step(mk(0, 1, 11, 32'h77, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0));
    step(mk(0, 0, 9,  32'h0,  32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0));
    step(mk(0, 0, 11, 32'h0,  32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
